bram_lsu: RTL and testbench

BRAM_LSU -- requirements
Module: bram_lsu

---
 rtl/bram_lsu_pkg.sv | 40 ++++
 rtl/bram_lsu_align.sv | 41 ++++
 rtl/bram_lsu.sv | 146 ++++++++++++++
 tb/tb_bram_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_lsu_pkg.sv
// Shared definitions for the BRAM load/store unit.
//   - RV32 load/store width codes (funct3)
//   - LSU control FSM state enum
//   - lsu_req_err(): decides whether an incoming request must be rejected
package bram_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  // A request is rejected when its width code is unknown (unsigned widths
  // make no sense for stores), when it is misaligned for its width, or when
  // the address falls outside the BRAM window.
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] byte_off,
                                       input logic       out_of_range);
    logic bad;
    bad = out_of_range;
    case (funct3)
      F3_B:    bad = bad;
      F3_BU:   bad = bad | we;
      F3_H:    bad = bad | byte_off[0];
      F3_HU:   bad = bad | we | byte_off[0];
      F3_W:    bad = bad | (byte_off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bram_lsu_align.sv
// lsu_align: purely combinational byte-lane handling for the LSU.
//   funct3     in  : width code of the request
//   byte_off   in  : address bits [1:0]
//   rword      in  : word read from the BRAM
//   wlane      in  : low 16 bits of the store data (right-aligned)
//   load_data  out : selected lane of rword, sign- or zero-extended
//   merge_word out : rword with the addressed byte/half replaced by wlane
module lsu_align
  import bram_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rword,
  input  logic [15:0] wlane,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [15:0] lane;

  always_comb begin
    // Move the addressed lane down to bit 0; only the low half is ever used.
    lane = 16'(rword >> {byte_off, 3'b000});

    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data = {24'h0, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane};
      F3_HU:   load_data = {16'h0, lane};
      default: load_data = rword;
    endcase

    merge_word = rword;
    case (funct3)
      F3_B:    merge_word[{byte_off, 3'b000} +: 8]       = wlane[7:0];
      F3_H:    merge_word[{byte_off[1], 4'b0000} +: 16]  = wlane;
      default: merge_word = rword;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// bram_lsu: single-outstanding load/store unit in front of a dual-port BRAM.
// Port A is used for writes, port B for reads. Sub-word stores are done as
// read-modify-write because the BRAM only has a whole-word write enable.
//   clk, rstn                    clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only when idle)
//   req_we, req_funct3           store flag and RV32 width code
//   req_addr, req_wdata          byte address and right-aligned store data
//   resp_valid                   one-cycle completion pulse
//   resp_rdata, resp_err         extended load data / rejection flag
//   mem_wea, mem_addra, mem_dina BRAM write port
//   mem_addrb, mem_doutb         BRAM read port
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_BITS    = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wea,
  output logic [31:0] mem_addra,
  output logic [31:0] mem_addrb,
  output logic [31:0] mem_dina,
  input  logic [31:0] mem_doutb
);

  lsu_state_t  state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic        wait_cnt;
  logic        wait_last;
  logic        accept;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  generate
    if (ADDR_BITS < 32) begin : g_range
      assign out_of_range = |req_addr[31:ADDR_BITS];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Ready is gated by rstn so it reads 0 throughout reset and rises as soon
  // as reset is released, without waiting for a clock edge.
  assign req_ready = (state == IDLE) && rstn;
  assign accept    = req_valid && req_ready;
  assign req_err   = lsu_req_err(req_we, req_funct3, req_addr[1:0], out_of_range);
  assign wait_last = (wait_cnt == 1'(READ_LATENCY - 1));

  // Both BRAM ports address the registered word; byte lanes are handled here.
  assign mem_addra = {addr_q[31:2], 2'b00};
  assign mem_addrb = {addr_q[31:2], 2'b00};

  // ---- cycle 0 -> 1: capture request, advance FSM ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      wait_cnt <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
        wait_cnt <= 1'b0;
      end else if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_nxt = RESP;
          else if (!req_we)             state_nxt = RD_WAIT;
          else if (req_funct3 == F3_W)  state_nxt = WRITE;
          else                          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // The read word is valid on the cycle after the last wait cycle.
        if (wait_last) state_nxt = we_q ? WRITE : RESP;
      end
      WRITE:   state_nxt = IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .rword      (mem_doutb),
    .wlane      (wdata_q[15:0]),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // ---- response / write cycle ----
  always_comb begin
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_wea    = 1'b0;
    mem_dina   = 32'h0;
    case (state)
      WRITE: begin
        mem_wea    = 1'b1;
        resp_valid = 1'b1;
        mem_dina   = (funct3_q == F3_W) ? wdata_q : merge_word;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'h0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bram_lsu.sv
// Bench for bram_lsu: two instances (read latency 1 and 2), each with its own
// BRAM model, checked against a byte-array reference memory.
module tb_bram_lsu;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic [1:0]  r_valid;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        rdy   [0:1];
  logic        rv    [0:1];
  logic [31:0] rdata [0:1];
  logic        rerr  [0:1];
  logic        wea   [0:1];
  logic [31:0] addra [0:1];
  logic [31:0] addrb [0:1];
  logic [31:0] dina  [0:1];
  logic [31:0] doutb [0:1];

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic [31:0] d1_s1;
  logic [7:0]  ref_b [0:1][0:4095];

  int n_chk  = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_lsu #(.READ_LATENCY(1), .ADDR_BITS(12)) u_dut0 (
    .clk(clk), .rstn(rstn), .req_valid(r_valid[0]), .req_ready(rdy[0]),
    .req_we(r_we), .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata),
    .resp_valid(rv[0]), .resp_rdata(rdata[0]), .resp_err(rerr[0]),
    .mem_wea(wea[0]), .mem_addra(addra[0]), .mem_addrb(addrb[0]),
    .mem_dina(dina[0]), .mem_doutb(doutb[0])
  );

  bram_lsu #(.READ_LATENCY(2), .ADDR_BITS(12)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_valid(r_valid[1]), .req_ready(rdy[1]),
    .req_we(r_we), .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata),
    .resp_valid(rv[1]), .resp_rdata(rdata[1]), .resp_err(rerr[1]),
    .mem_wea(wea[1]), .mem_addra(addra[1]), .mem_addrb(addrb[1]),
    .mem_dina(dina[1]), .mem_doutb(doutb[1])
  );

  // BRAM models: one-cycle and two-cycle registered reads.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem0[i] <= 32'h0;
    end else begin
      if (wea[0]) mem0[addra[0][11:2]] <= dina[0];
      doutb[0] <= mem0[addrb[0][11:2]];
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 32'h0;
    end else begin
      if (wea[1]) mem1[addra[1][11:2]] <= dina[1];
      d1_s1    <= mem1[addrb[1][11:2]];
      doutb[1] <= d1_s1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
    if (!legal) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    return (a % ref_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int inst, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = ref_size(f3);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[inst][a + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int inst, input logic [31:0] a);
    logic [31:0] v;
    int base;
    base = int'(a & 32'hFFC);
    v = 32'h0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_b[inst][base + i]) << (8 * i));
    return v;
  endfunction

  function automatic logic [31:0] model_word(input int inst, input logic [31:0] a);
    return (inst == 0) ? mem0[a[11:2]] : mem1[a[11:2]];
  endfunction

  // ---------------- one request, fully checked ----------------
  task automatic do_req(input int inst, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rdata;
    int          rl, e_lat, e_wea;
    int          resp_cnt, resp_cyc, wea_cnt, wea_cyc;
    logic        g_err;
    rl       = inst + 1;
    e_err    = ref_err(we, f3, a);
    e_rdata  = (e_err || we) ? 32'h0 : ref_load(inst, f3, a);
    e_wea    = (we && !e_err) ? 1 : 0;
    e_lat    = (e_err || (we && f3 == 3'd2)) ? 1 : rl + 1;
    if (we && !e_err)
      for (int i = 0; i < ref_size(f3); i++) ref_b[inst][a + i] = wd[8 * i +: 8];

    @(negedge clk);
    chk("ready_idle", 32'(rdy[inst]), 32'd1);
    r_we = we; r_f3 = f3; r_addr = a; r_wdata = wd;
    r_valid[inst] = 1'b1;

    resp_cnt = 0; resp_cyc = 0; wea_cnt = 0; wea_cyc = 0;
    got = 32'h0; g_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rv[inst]) begin
        resp_cnt++;
        if (resp_cnt == 1) begin resp_cyc = c; got = rdata[inst]; g_err = rerr[inst]; end
      end
      if (wea[inst]) begin wea_cnt++; wea_cyc = c; end
      if (c == e_lat + 1) chk("ready_back", 32'(rdy[inst]), 32'd1);
      // Garbage requests while busy must be ignored; quiet before idle returns.
      r_valid[inst] = (c < e_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      r_we = 1'($urandom); r_f3 = 3'($urandom); r_addr = $urandom; r_wdata = $urandom;
    end
    chk("resp_count", 32'(resp_cnt), 32'd1);
    chk("resp_cycle", 32'(resp_cyc), 32'(e_lat));
    chk("resp_err", 32'(g_err), 32'(e_err));
    chk("resp_rdata", got, e_rdata);
    chk("wea_count", 32'(wea_cnt), 32'(e_wea));
    if (e_wea == 1) chk("wea_cycle", 32'(wea_cyc), 32'(e_lat));
    if (a < 32'd4096) chk("mem_word", model_word(inst, a), ref_word(inst, a));
  endtask

  logic [31:0] got;

  initial begin
    rstn = 1'b0; clr = 1'b1;
    r_valid = 2'b00; r_we = 1'b0; r_f3 = 3'b0; r_addr = 32'h0; r_wdata = 32'h0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4096; i++) ref_b[k][i] = 8'h0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      chk("rst_valid", 32'(rv[k]), 32'd0);
      chk("rst_err",   32'(rerr[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_wea",   32'(wea[k]), 32'd0);
      chk("rst_addra", addra[k], 32'h0);
      chk("rst_addrb", addrb[k], 32'h0);
      chk("rst_dina",  dina[k], 32'h0);
    end
    rstn = 1'b1;
    #1;
    chk("rel_ready0", 32'(rdy[0]), 32'd1);
    chk("rel_ready1", 32'(rdy[1]), 32'd1);

    // Directed scenarios on both latencies.
    for (int k = 0; k < 2; k++) begin
      do_req(k, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, got);
      do_req(k, 1'b0, 3'b010, 32'h010, 32'h0, got);
      chk("lw_x10", got, 32'hDEADBEEF);
      do_req(k, 1'b1, 3'b000, 32'h011, 32'h00000080, got);
      do_req(k, 1'b0, 3'b000, 32'h011, 32'h0, got);
      chk("lb_x11", got, 32'hFFFFFF80);
      do_req(k, 1'b0, 3'b100, 32'h011, 32'h0, got);
      chk("lbu_x11", got, 32'h00000080);
      do_req(k, 1'b0, 3'b010, 32'h010, 32'h0, got);
      chk("lw_after_sb", got, 32'hDEAD80EF);
      do_req(k, 1'b0, 3'b001, 32'h013, 32'h0, got);
      do_req(k, 1'b1, 3'b010, 32'h012, 32'h55555555, got);
      do_req(k, 1'b0, 3'b010, 32'h1000, 32'h0, got);
      do_req(k, 1'b0, 3'b011, 32'h010, 32'h0, got);
      do_req(k, 1'b1, 3'b100, 32'h014, 32'h12, got);
      do_req(k, 1'b1, 3'b001, 32'h012, 32'h00001234, got);
      do_req(k, 1'b0, 3'b010, 32'h010, 32'h0, got);
      chk("lw_after_sh", got, 32'h123480EF);
    end

    // Reset in the middle of a read-modify-write on the latency-2 instance.
    @(negedge clk);
    r_we = 1'b1; r_f3 = 3'b000; r_addr = 32'h020; r_wdata = 32'hA5; r_valid[1] = 1'b1;
    @(negedge clk);
    r_valid[1] = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy[1]), 32'd0);
    chk("midrst_valid", 32'(rv[1]), 32'd0);
    chk("midrst_wea",   32'(wea[1]), 32'd0);
    chk("midrst_addra", addra[1], 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("midrst_rel_ready", 32'(rdy[1]), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (wea[1] || rv[1]) seen++;
      end
      chk("midrst_no_activity", 32'(seen), 32'd0);
    end
    chk("midrst_mem", model_word(1, 32'h020), ref_word(1, 32'h020));

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h1000;
      else a = 32'($urandom_range(0, 127));
      do_req(i % 2, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
